// File: rtl/alu_issue.sv
// Operand-fetch / issue stage feeding the ALU: decodes one instruction per cycle,
// reads and forwards operands, and holds the issued bundle in a single pipeline register.
`timescale 1ns/1ps
module alu_issue #(
  parameter int NREG = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             instr,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [$clog2(NREG)-1:0] rf_ra1,
  output logic [$clog2(NREG)-1:0] rf_ra2,
  input  logic [31:0]             rf_rd1,
  input  logic [31:0]             rf_rd2,
  input  logic                    wb_we,
  input  logic [$clog2(NREG)-1:0] wb_rd,
  input  logic [31:0]             wb_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             In1,
  output logic [31:0]             In2,
  output logic [3:0]              Opcode,
  output logic [3:0]              Cond,
  output logic                    S,
  output logic [2:0]              SR_Cont,
  output logic [4:0]              SR_Bit,
  output logic [15:0]             Immediate,
  output logic [2:0]              Rd,
  output logic                    rd_we
);

  localparam int RAW = $clog2(NREG);

  // R0 is hard zero; a same-cycle writeback overrides the register file.
  function automatic logic [31:0] fwd_operand(
    input logic [RAW-1:0] addr,
    input logic [31:0]    rf_data,
    input logic           we,
    input logic [RAW-1:0] wa,
    input logic [31:0]    wd
  );
    logic [31:0] v;
    if (addr == {RAW{1'b0}}) begin
      v = 32'd0;
    end else if (we && (wa == addr)) begin
      v = wd;
    end else begin
      v = rf_data;
    end
    return v;
  endfunction

  logic        w_imm_form;
  logic        w_squash;
  logic        w_accept;
  logic [31:0] w_in1;
  logic [31:0] w_in2;
  logic [2:0]  w_sr_cont;
  logic [4:0]  w_sr_bit;
  logic        w_rd_we;

  logic        r_out_valid;
  logic [31:0] r_in1;
  logic [31:0] r_in2;
  logic [3:0]  r_opcode;
  logic [3:0]  r_cond;
  logic        r_s;
  logic [2:0]  r_sr_cont;
  logic [4:0]  r_sr_bit;
  logic [15:0] r_immediate;
  logic [2:0]  r_rd;
  logic        r_rd_we;

  assign rf_ra1   = instr[16 +: RAW];
  assign rf_ra2   = instr[13 +: RAW];
  assign in_ready = !rst && (!r_out_valid || out_ready);
  assign w_accept = in_valid && in_ready;
  assign w_squash = (instr[31:28] == 4'b1111);

  // Decode the incoming word into the next bundle contents.
  always_comb begin
    w_imm_form = instr[22];
    w_in1      = fwd_operand(rf_ra1, rf_rd1, wb_we, wb_rd, wb_data);
    w_in2      = fwd_operand(rf_ra2, rf_rd2, wb_we, wb_rd, wb_data);
    w_sr_cont  = 3'b000;
    w_sr_bit   = 5'd0;
    if (w_imm_form) begin
      w_in2 = {{16{instr[15]}}, instr[15:0]};
    end else begin
      w_sr_cont = instr[12:10];
      w_sr_bit  = instr[9:5];
    end
    w_rd_we = !((instr[27:24] == 4'b1011) || (instr[21:19] == 3'd0));
  end

  // Bundle register: reset, then flush, then load on accept, then drain on consume.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_in1       <= 32'd0;
      r_in2       <= 32'd0;
      r_opcode    <= 4'd0;
      r_cond      <= 4'd0;
      r_s         <= 1'b0;
      r_sr_cont   <= 3'd0;
      r_sr_bit    <= 5'd0;
      r_immediate <= 16'd0;
      r_rd        <= 3'd0;
      r_rd_we     <= 1'b0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_accept && !w_squash) begin
      r_out_valid <= 1'b1;
      r_in1       <= w_in1;
      r_in2       <= w_in2;
      r_opcode    <= instr[27:24];
      r_cond      <= instr[31:28];
      r_s         <= instr[23];
      r_sr_cont   <= w_sr_cont;
      r_sr_bit    <= w_sr_bit;
      r_immediate <= instr[15:0];
      r_rd        <= instr[21:19];
      r_rd_we     <= w_rd_we;
    end else if (out_ready) begin
      // A squashed accept lands here too: it only drains what was held.
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_out_valid;
    end
  end

  assign out_valid = r_out_valid;
  assign In1       = r_in1;
  assign In2       = r_in2;
  assign Opcode    = r_opcode;
  assign Cond      = r_cond;
  assign S         = r_s;
  assign SR_Cont   = r_sr_cont;
  assign SR_Bit    = r_sr_bit;
  assign Immediate = r_immediate;
  assign Rd        = r_rd;
  assign rd_we     = r_rd_we;

endmodule

// File: doc/alu_issue.md
# alu_issue

Operand-fetch and issue stage directly upstream of the `alu`. Accepts one 32-bit instruction per cycle over a valid/ready handshake, decodes it into the ALU control fields, reads the register file, applies writeback forwarding, and holds the result in a single pipeline register that drives the ALU inputs. Provides full throughput, back-pressure, flush, and never-condition squash.

## Interface
- `NREG`, default 8. Number of architectural registers. Fixed at 8 by the 3-bit encoding; R0 reads as zero.
- `clk`  in  1  Clock; all state updates on the rising edge.
- `rst`  in  1  Reset. Synchronous and active-high.
- `instr`  in  32  Instruction word.
- `in_valid`  in  1  `instr` is valid.
- `in_ready`  out  1  Stage accepts `instr` this cycle.
- `flush`  in  1  Discard the held instruction and any instruction accepted this cycle.
- `rf_ra1`, `rf_ra2`  out  3  Register-file read addresses (Rn, Rm). Combinational from `instr`.
- `rf_rd1`, `rf_rd2`  in  32  Register-file read data, same cycle.
- `wb_we`  in  1  Writeback valid.
- `wb_rd`  in  3  Writeback register.
- `wb_data`  in  32  Writeback data.
- `out_valid`  out  1  Issued bundle valid.
- `out_ready`  in  1  ALU/downstream consumes the bundle.
- `In1`, `In2`  out  32  ALU operands.
- `Opcode`  out  4;  `Cond`  out  4;  `S`  out  1;  `SR_Cont`  out  3;  `SR_Bit`  out  5;  `Immediate`  out  16.  ALU control fields.
- `Rd`  out  3;  `rd_we`  out  1.  Destination and write enable passed to writeback.

## Operation
- Encoding: [31:28] Cond, [27:24] Opcode, [23] S, [22] I, [21:19] Rd, [18:16] Rn, [15:0] payload.
- I=1: payload is the 16-bit immediate; `In2` = sign-extend(payload).
- I=0: [15:13] Rm, [12:10] SR_Cont, [9:5] SR_Bit, [4:0] reserved (ignored); `In2` = Rm operand.
- I=1: `SR_Cont` = 000 and `SR_Bit` = 0. `Immediate` = instr[15:0] in both forms.
- `rd_we` = 0 when Opcode = 1011 (compare) or Rd = 0; otherwise 1.
- Operand selection for Rn and Rm: R0 gives 0; else if `wb_we` and `wb_rd` equal the register, use `wb_data`; else use `rf_rd1`/`rf_rd2`. Forwarding takes priority over the register file.
- Accept = `in_valid && in_ready`. `in_ready` = !rst && (!out_valid || out_ready).
- Squash: an accepted instruction with Cond = 1111 (never) is consumed. It does not load the register. `out_valid` clears if the held bundle is consumed the same cycle.
- Register update priority: rst, then flush, then accept (non-squash), then consume.
  - flush: `out_valid` <= 0, and any same-cycle accept is discarded.
  - accept (non-squash): load all bundle fields; `out_valid` <= 1.
  - consume without accept: `out_valid` <= 0. Data fields hold their last value.

## Timing
- Latency: 1 cycle. An instruction accepted at edge N appears on the outputs after edge N.
- Throughput: 1 instruction/cycle while `out_ready` = 1.
- Stall: while `out_valid && !out_ready`, `in_ready` = 0 and all outputs hold stable.
- Reset: `out_valid` = 0, `in_ready` = 0 during rst. `In1`, `In2`, `Opcode`, `Cond`, `S`, `SR_Cont`, `SR_Bit`, `Immediate`, `Rd`, `rd_we` = 0. From the first cycle after rst falls, `in_ready` = 1.
- Reset mid-stall discards the held bundle.
- Flush and consume in the same cycle: no double-consume; `out_valid` = 0 next cycle.
- Forwarding is sampled in the accept cycle only. A writeback arriving while a bundle is stalled does not update the held operands; the writeback unit guarantees no such hazard.

## Test plan
- Compare, immediate form: `instr` = 0x0BC10014, `rf_rd1` = 15, `out_ready` = 1 -> next cycle `out_valid` = 1, `Opcode` = 1011, `S` = 1, `In1` = 15, `In2` = 20, `rd_we` = 0. Repeat with imm 0xFFFF -> `In2` = 0xFFFFFFFF.
- Register form: `instr` = 0x041384A0, R3 = 7, R4 = 9 -> `In1` = 7, `In2` = 9, `SR_Cont` = 001, `SR_Bit` = 5, `Rd` = 2, `rd_we` = 1.
- Forwarding: same instruction with `wb_we` = 1, `wb_rd` = 4, `wb_data` = 0x80000000 -> `In2` = 0x80000000. Rn = 0 with `rf_rd1` = 0xDEAD -> `In1` = 0.
- Back-pressure: 3 back-to-back instructions, `out_ready` low for 2 cycles after the first issues -> `in_ready` = 0 for those cycles, first bundle held stable, all 3 issue in order with none lost.
- Squash and flush: Cond = 1111 accepted -> no `out_valid`. `flush` while holding a bundle with `in_valid` = 1 -> both discarded, `out_valid` = 0 next cycle.
- Reset: assert rst for 1 cycle while `out_valid` = 1 and stalled -> all outputs 0 next cycle, `in_ready` = 1 after rst deasserts.
